// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared stack op encodings and default geometry
package stack_pkg;
    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b11;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;
endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - stack register file, one sync write port, one async read port
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; the stack pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/hw_stack.sv
// rtl/hw_stack.sv - LIFO responder for the processor push/pop interface
module hw_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clear_err
);
    localparam logic [PTR_W:0] SP_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] SP_ONE = (PTR_W+1)'(1);

    logic [PTR_W:0]   sp;
    logic [PTR_W:0]   sp_m1;
    logic [1:0]       op;
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [WIDTH-1:0] top_data;
    logic             push_err;
    logic             pop_err;

    assign op    = {push, pop};
    assign sp_m1 = sp - SP_ONE;
    assign full  = (sp == SP_MAX);
    assign empty = (sp == '0);
    assign count = sp;

    assign push_err = (op == OP_PUSH) && full;
    assign pop_err  = (op == OP_POP) && empty;

    // A swap overwrites the current top; a push writes the slot above it.
    assign mem_we    = ((op == OP_PUSH) && !full) || ((op == OP_SWAP) && !empty);
    assign mem_waddr = (op == OP_SWAP) ? sp_m1[PTR_W-1:0] : sp[PTR_W-1:0];

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (data_in),
        .raddr (sp_m1[PTR_W-1:0]),
        .rdata (top_data)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sp        <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (!full) begin
                        sp <= sp + SP_ONE;
                    end
                end
                OP_POP: begin
                    if (!empty) begin
                        data_out <= top_data;
                        sp       <= sp_m1;
                    end
                end
                OP_SWAP: begin
                    // On an empty stack the pushed word passes straight through.
                    data_out <= empty ? data_in : top_data;
                end
                default: begin
                end
            endcase
            // An error event on the same edge as clear_err takes priority.
            overflow  <= (overflow & ~clear_err) | push_err;
            underflow <= (underflow & ~clear_err) | pop_err;
        end
    end
endmodule

// File: tb/tb_hw_stack.sv
// tb/tb_hw_stack.sv - directed self-checking bench for hw_stack
module tb_hw_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clk;
    logic             resetN;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             underflow;
    logic             clear_err;

    int checks = 0;
    int errors = 0;

    hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .clear_err (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic ce);
        push = p; pop = q; data_in = d; clear_err = ce;
        tick();
        push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        push = 0; pop = 0; data_in = '0; clear_err = 0;
        resetN = 1'b0;
        tick();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00
            || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d empty=%b full=%b data_out=%h ovf=%b unf=%b, want 0 1 0 00 0 0",
                     count, empty, full, data_out, overflow, underflow);
        end
        resetN = 1'b1;
    endtask

    task automatic test_lifo();
        logic [7:0] pushed [3];
        pushed[0] = 8'h11; pushed[1] = 8'h22; pushed[2] = 8'h33;
        apply_reset();
        for (int i = 0; i < 3; i++) drive(1, 0, pushed[i], 0);
        checks++;
        if (count !== 5'd3) begin
            errors++;
            $display("FAIL lifo_count_after_push: got %0d want 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'h00, 0);
            checks++;
            if (data_out !== pushed[2-i] || count !== 5'(2-i)) begin
                errors++;
                $display("FAIL lifo_pop%0d: data_out=%h count=%0d want %h %0d",
                         i, data_out, count, pushed[2-i], 2-i);
            end
        end
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL lifo_end: empty=%b ovf=%b unf=%b want 1 0 0", empty, overflow, underflow);
        end
    endtask

    task automatic test_full_overflow();
        apply_reset();
        for (int i = 0; i < 16; i++) drive(1, 0, 8'(i), 0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full: full=%b count=%0d ovf=%b want 1 16 0", full, count, overflow);
        end
        drive(1, 0, 8'hAA, 0);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL overflow: ovf=%b count=%0d want 1 16", overflow, count);
        end
        drive(0, 1, 8'h00, 0);
        checks++;
        if (data_out !== 8'h0F || count !== 5'd15 || full !== 1'b0) begin
            errors++;
            $display("FAIL pop_after_full: data_out=%h count=%0d full=%b want 0f 15 0", data_out, count, full);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        drive(0, 1, 8'h00, 0);
        checks++;
        if (underflow !== 1'b1 || data_out !== 8'h00 || count !== 5'd0) begin
            errors++;
            $display("FAIL underflow: unf=%b data_out=%h count=%0d want 1 00 0", underflow, data_out, count);
        end
        drive(0, 0, 8'h00, 1);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_err: unf=%b want 0", underflow);
        end
        drive(0, 1, 8'h00, 1);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: unf=%b want 1", underflow);
        end
    endtask

    task automatic test_swap();
        apply_reset();
        drive(1, 0, 8'h05, 0);
        drive(1, 1, 8'h09, 0);
        checks++;
        if (data_out !== 8'h05 || count !== 5'd1) begin
            errors++;
            $display("FAIL swap: data_out=%h count=%0d want 05 1", data_out, count);
        end
        drive(0, 1, 8'h00, 0);
        checks++;
        if (data_out !== 8'h09 || count !== 5'd0) begin
            errors++;
            $display("FAIL pop_after_swap: data_out=%h count=%0d want 09 0", data_out, count);
        end
    endtask

    task automatic test_bypass();
        drive(1, 1, 8'h7E, 0);
        checks++;
        if (data_out !== 8'h7E || count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL bypass: data_out=%h count=%0d ovf=%b unf=%b want 7e 0 0 0",
                     data_out, count, overflow, underflow);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 8'h44, 0);
        drive(1, 0, 8'h55, 0);
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: count=%0d empty=%b data_out=%h want 0 1 00", count, empty, data_out);
        end
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 8'h66, 0);
        drive(0, 1, 8'h00, 0);
        checks++;
        if (data_out !== 8'h66 || count !== 5'd0) begin
            errors++;
            $display("FAIL after_reset_release: data_out=%h count=%0d want 66 0", data_out, count);
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_full_overflow();
        test_underflow();
        test_swap();
        test_bypass();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
